// File: rtl/cfg_write_arbiter.sv
// rtl/cfg_write_arbiter.sv - two-requester write arbiter owning the PWM control-register bank
module cfg_write_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [6:0] req0_addr,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [6:0] req1_addr,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       lock,
  output logic [4:0] wr_strobe,
  output logic       wr_err,
  output logic       last_grant
);

  localparam logic [6:0] ADDR_LOCK = 7'h05;
  localparam logic [6:0] NUM_DATA_REGS = 7'd5;

  logic       ptr;
  logic       grant0;
  logic       grant1;
  logic       accept;
  logic       src;
  logic [6:0] addr;
  logic [7:0] data;
  logic [7:0] regs [0:4];

  // Contention goes to req[ptr] in round-robin mode, otherwise req0 always wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      if (RR_EN && ptr) grant1 = 1'b1;
      else              grant0 = 1'b1;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  assign req0_ready = rst_n & grant0;
  assign req1_ready = rst_n & grant1;
  assign accept     = req0_ready | req1_ready;
  assign src        = req1_ready;
  assign addr       = src ? req1_addr : req0_addr;
  assign data       = src ? req1_data : req0_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) regs[i] <= 8'h00;
      lock       <= 1'b0;
      wr_strobe  <= 5'b0;
      wr_err     <= 1'b0;
      last_grant <= 1'b0;
      ptr        <= 1'b0;
    end else begin
      wr_strobe <= 5'b0;
      wr_err    <= 1'b0;
      if (accept) begin
        last_grant <= src;
        if (RR_EN) ptr <= ~src;
        // Bad or locked-out writes are still accepted so neither requester stalls.
        if (addr < NUM_DATA_REGS) begin
          if (!src || !lock) begin
            regs[addr[2:0]]      <= data;
            wr_strobe[addr[2:0]] <= 1'b1;
          end else begin
            wr_err <= 1'b1;
          end
        end else if (addr == ADDR_LOCK && !src) begin
          lock <= data[0];
        end else begin
          wr_err <= 1'b1;
        end
      end
    end
  end

  assign en_reg_out_7_0  = regs[0];
  assign en_reg_out_15_8 = regs[1];
  assign en_reg_pwm_7_0  = regs[2];
  assign en_reg_pwm_15_8 = regs[3];
  assign pwm_duty_cycle  = regs[4];

endmodule

// File: tb/tb_cfg_write_arbiter.sv
// tb/tb_cfg_write_arbiter.sv - scoreboard bench for cfg_write_arbiter (round-robin and fixed-priority)
module tb_cfg_write_arbiter;

  typedef struct packed {
    logic [4:0][7:0] regs;
    logic            lock;
    logic [4:0]      strobe;
    logic            err;
    logic            lg;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [6:0] req0_addr, req1_addr;
  logic [7:0] req0_data, req1_data;

  logic       req0_ready, req1_ready;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       lock, wr_err, last_grant;
  logic [4:0] wr_strobe;

  logic       fp_req0_ready, fp_req1_ready;
  logic [7:0] fp_out_7_0, fp_out_15_8, fp_pwm_7_0, fp_pwm_15_8, fp_duty;
  logic       fp_lock, fp_wr_err, fp_last_grant;
  logic [4:0] fp_wr_strobe;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_reg [5];
  logic       m_lock;
  logic       m_lg;
  exp_t       sb_q [$];

  always #5 clk = ~clk;

  cfg_write_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .lock(lock), .wr_strobe(wr_strobe),
    .wr_err(wr_err), .last_grant(last_grant)
  );

  cfg_write_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(fp_req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(fp_req1_ready),
    .en_reg_out_7_0(fp_out_7_0), .en_reg_out_15_8(fp_out_15_8),
    .en_reg_pwm_7_0(fp_pwm_7_0), .en_reg_pwm_15_8(fp_pwm_15_8),
    .pwm_duty_cycle(fp_duty), .lock(fp_lock), .wr_strobe(fp_wr_strobe),
    .wr_err(fp_wr_err), .last_grant(fp_last_grant)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_snapshot(input logic [4:0] strobe, input logic err);
    exp_t e;
    for (int i = 0; i < 5; i++) e.regs[i] = m_reg[i];
    e.lock   = m_lock;
    e.strobe = strobe;
    e.err    = err;
    e.lg     = m_lg;
    return e;
  endfunction

  task automatic compare_outputs(input string tag, input exp_t e);
    check_eq({tag, " reg00"}, en_reg_out_7_0, e.regs[0]);
    check_eq({tag, " reg01"}, en_reg_out_15_8, e.regs[1]);
    check_eq({tag, " reg02"}, en_reg_pwm_7_0, e.regs[2]);
    check_eq({tag, " reg03"}, en_reg_pwm_15_8, e.regs[3]);
    check_eq({tag, " reg04"}, pwm_duty_cycle, e.regs[4]);
    check_eq({tag, " lock"}, lock, e.lock);
    check_eq({tag, " wr_strobe"}, wr_strobe, e.strobe);
    check_eq({tag, " wr_err"}, wr_err, e.err);
    check_eq({tag, " last_grant"}, last_grant, e.lg);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
    m_lock = 1'b0;
    m_lg   = 1'b0;
    sb_q.delete();
  endtask

  // One cycle: drive at posedge+1, check readies, push expected, compare at next posedge+1.
  task automatic drive(input string tag,
                       input logic v0, input logic [6:0] a0, input logic [7:0] d0,
                       input logic v1, input logic [6:0] a1, input logic [7:0] d1,
                       input logic eg0, input logic eg1);
    logic [4:0] strobe;
    logic       err;
    logic [6:0] a;
    logic [7:0] d;
    exp_t       e;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    #1;
    check_eq({tag, " req0_ready"}, req0_ready, eg0);
    check_eq({tag, " req1_ready"}, req1_ready, eg1);
    strobe = 5'b0;
    err    = 1'b0;
    if (eg0 || eg1) begin
      a    = eg1 ? a1 : a0;
      d    = eg1 ? d1 : d0;
      m_lg = eg1;
      if (a <= 7'h04) begin
        if (eg1 && m_lock) err = 1'b1;
        else begin
          m_reg[a] = d;
          strobe[a] = 1'b1;
        end
      end else if (a == 7'h05 && eg0) begin
        m_lock = d[0];
      end else begin
        err = 1'b1;
      end
    end
    sb_q.push_back(model_snapshot(strobe, err));
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    compare_outputs(tag, e);
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_addr = 7'h00; req0_data = 8'h00;
    req1_valid = 1'b0; req1_addr = 7'h00; req1_data = 8'h00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    model_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_addr = 7'h00; req0_data = 8'hAA;
    req1_valid = 1'b1; req1_addr = 7'h01; req1_data = 8'hBB;
    #3;
    check_eq("rst req0_ready", req0_ready, 1'b0);
    check_eq("rst req1_ready", req1_ready, 1'b0);
    @(posedge clk); #1;
    compare_outputs("rst", model_snapshot(5'b0, 1'b0));
    idle_inputs();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    drive("single", 1, 7'h04, 8'h80, 0, 7'h00, 8'h00, 1, 0);
    check_eq("single duty", pwm_duty_cycle, 8'h80);
    check_eq("single strobe", wr_strobe, 5'b10000);
    drive("idle", 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0, 0);

    drive("badaddr", 0, 7'h00, 8'h00, 1, 7'h10, 8'h55, 0, 1);
    check_eq("badaddr err", wr_err, 1'b1);

    drive("rr c0", 1, 7'h00, 8'h11, 1, 7'h01, 8'h22, 1, 0);
    drive("rr c1", 0, 7'h00, 8'h00, 1, 7'h01, 8'h22, 0, 1);
    check_eq("rr reg00", en_reg_out_7_0, 8'h11);
    check_eq("rr reg01", en_reg_out_15_8, 8'h22);
    drive("rr2 c0", 1, 7'h03, 8'h33, 1, 7'h04, 8'h44, 1, 0);
    drive("rr2 c1", 0, 7'h00, 8'h00, 1, 7'h04, 8'h44, 0, 1);

    drive("lock set", 1, 7'h05, 8'h01, 0, 7'h00, 8'h00, 1, 0);
    drive("locked r1", 0, 7'h00, 8'h00, 1, 7'h02, 8'hFF, 0, 1);
    check_eq("locked pwm", en_reg_pwm_7_0, 8'h00);
    drive("locked r0", 1, 7'h02, 8'hFF, 0, 7'h00, 8'h00, 1, 0);
    check_eq("locked r0 strobe", wr_strobe, 5'b00100);
    drive("r1 lockaddr", 0, 7'h00, 8'h00, 1, 7'h05, 8'h00, 0, 1);
    drive("unlock", 1, 7'h05, 8'h00, 0, 7'h00, 8'h00, 1, 0);
    drive("unlocked r1", 0, 7'h00, 8'h00, 1, 7'h01, 8'h5A, 0, 1);
    drive("b2b 0", 1, 7'h00, 8'hA1, 0, 7'h00, 8'h00, 1, 0);
    drive("b2b 1", 1, 7'h00, 8'hA2, 0, 7'h00, 8'h00, 1, 0);
    drive("rr burst0", 1, 7'h7F, 8'h01, 1, 7'h03, 8'h77, 0, 1);
    drive("rr burst1", 1, 7'h7F, 8'h01, 0, 7'h00, 8'h00, 1, 0);

    // Mid-stream reset with both requesters active.
    req0_valid = 1'b1; req0_addr = 7'h00; req0_data = 8'hEE;
    req1_valid = 1'b1; req1_addr = 7'h01; req1_data = 8'hDD;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("midrst req0_ready", req0_ready, 1'b0);
    check_eq("midrst req1_ready", req1_ready, 1'b0);
    compare_outputs("midrst", model_snapshot(5'b0, 1'b0));
    @(posedge clk); #1;
    compare_outputs("midrst hold", model_snapshot(5'b0, 1'b0));
    idle_inputs();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("sb empty", sb_q.size(), 0);

    // Fixed-priority instance: req0 wins every contended cycle.
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'b1; req0_addr = 7'h00; req0_data = 8'(8'h10 + i);
      req1_valid = 1'b1; req1_addr = 7'h01; req1_data = 8'h99;
      #1;
      check_eq("fp req0_ready", fp_req0_ready, 1'b1);
      check_eq("fp req1_ready", fp_req1_ready, 1'b0);
      @(posedge clk); #1;
      check_eq("fp reg00", fp_out_7_0, 8'(8'h10 + i));
      check_eq("fp last_grant", fp_last_grant, 1'b0);
    end
    check_eq("fp reg01", fp_out_15_8, 8'h00);
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cfg_write_arbiter.md
# cfg_write_arbiter

Arbitrated write port for the chip's control-register bank: enable-out, PWM-enable and PWM duty-cycle. Two requesters share the bank over independent valid/ready channels. Requester 0 is the decoded SPI host write stream; requester 1 is an on-chip autonomous engine, such as a fade or sequencer. The block arbitrates between them, owns the five control registers plus a lock register, and pulses per-register update strobes for downstream PWM logic.

## Interface
Parameters:
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority with req0 always winning.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 write request
- req0_addr  in  7  requester 0 register address
- req0_data  in  8  requester 0 write data
- req0_ready  out  1  requester 0 accepted this cycle
- req1_valid, req1_addr, req1_data, req1_ready  same as above, for requester 1
- en_reg_out_7_0  out  8  register 0x00
- en_reg_out_15_8  out  8  register 0x01
- en_reg_pwm_7_0  out  8  register 0x02
- en_reg_pwm_15_8  out  8  register 0x03
- pwm_duty_cycle  out  8  register 0x04
- lock  out  1  register 0x05, bit 0
- wr_strobe  out  5  one-cycle pulse; bit i = register 0x0i was updated
- wr_err  out  1  one-cycle pulse; an accepted write was dropped
- last_grant  out  1  requester index of the most recent accepted write

## Operation
- Transfer occurs when reqK_valid && reqK_ready. A requester holds addr and data stable and keeps valid high until accepted; it never withdraws valid.
- reqK_ready is combinational: reqK_valid && grantK. At most one ready is high per cycle. Both readies are forced 0 while rst_n is low.
- Arbitration uses a 1-bit priority pointer `ptr` (reset value 0).
  - Only one valid: that requester is granted.
  - Both valid, RR_EN=1: req[ptr] is granted. After any accepted write, ptr becomes the complement of the granted index.
  - Both valid, RR_EN=0: req0 is granted. ptr is unused.
- Write decode for an accepted transfer:
  - addr 0x00–0x04, source req0: register written, matching wr_strobe bit pulses.
  - addr 0x00–0x04, source req1, lock=0: register written, strobe pulses.
  - addr 0x00–0x04, source req1, lock=1: write dropped, wr_err pulses, no strobe.
  - addr 0x05, source req0: lock <= data[0]; no wr_strobe bit, no error.
  - addr 0x05, source req1: dropped, wr_err pulses.
  - addr 0x06–0x7F: dropped, wr_err pulses.
- Dropped writes are still accepted (ready high) so requesters never stall on a bad address.
- last_grant updates on every accepted transfer, including dropped ones.
- Reset (async, any time) sets:
  - all six registers to 0; lock = 0
  - wr_strobe = 0, wr_err = 0, last_grant = 0, ptr = 0
  - A transfer in flight at reset assertion is lost and its target register reads 0.

## Timing
- Grant latency is 0 cycles: ready rises in the same cycle valid is presented, if granted.
- Write latency is 1 cycle. For a transfer accepted in cycle N, the register value, wr_strobe, wr_err and last_grant are visible in cycle N+1. Strobes and errors are high for exactly cycle N+1 unless another write follows.
- Throughput is one write per cycle sustained. Back-to-back writes to the same register: the last one wins; the strobe stays high for both cycles.
- Starvation bound with RR_EN=1: the losing requester is granted in the next cycle. With RR_EN=0, req1 may starve indefinitely; this is accepted.
- A lock write in cycle N applies to req1 writes accepted in cycle N+1 or later. req1 cannot write in cycle N, because req0 holds the grant that cycle.
- Reset release: the first grant is possible in the first clk edge after rst_n rises.

## Test plan
- Reset mid-stream: assert rst_n=0 while both valid -> all registers, lock, wr_strobe, wr_err and last_grant are 0; both readies are 0 during reset.
- Single write: req0 writes 0x04=0x80 -> req0_ready=1 the same cycle; next cycle pwm_duty_cycle=0x80, wr_strobe=5'b10000 for one cycle, last_grant=0.
- Contention with RR_EN=1: both valid, req0 0x00=0x11 and req1 0x01=0x22, held -> cycle 0 grants req0, cycle 1 grants req1; registers read 0x11 and 0x22. A new simultaneous pair then grants req0 first again.
- Lock: req0 writes 0x05=0x01, then req1 writes 0x02=0xFF -> accepted, wr_err pulses, en_reg_pwm_7_0 stays 0x00. req0 then writes 0x02=0xFF -> succeeds, strobe bit 2 pulses.
- Bad address: req1 writes 0x10=0x55 -> ready=1, wr_err pulses, wr_strobe=0, no register changes.
- RR_EN=0: both held valid for 4 cycles with distinct writes -> req0 is granted all 4 cycles and req1_ready stays 0.
